// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access controller.
// Lane steering, load extension, stall, branch resolve and halt latch.
module mem_access_unit #(
  parameter int NB_DATA = 32,
  parameter int TIMEOUT = 16
) (
  input  logic               i_clock,
  input  logic               i_reset_n,
  input  logic               MEM_mem_read,
  input  logic               MEM_mem_write,
  input  logic               MEM_byte_en,
  input  logic               MEM_halfword_en,
  input  logic               MEM_word_en,
  input  logic               i_load_unsigned,
  input  logic [NB_DATA-1:0] MEM_alu_result,
  input  logic [NB_DATA-1:0] MEM_data_b,
  input  logic               MEM_branch,
  input  logic               MEM_zero,
  input  logic [NB_DATA-1:0] MEM_branch_addr,
  input  logic               MEM_hlt,
  output logic               o_dmem_req,
  output logic               o_dmem_we,
  output logic [NB_DATA-1:0] o_dmem_addr,
  output logic [3:0]         o_dmem_be,
  output logic [NB_DATA-1:0] o_dmem_wdata,
  input  logic               i_dmem_ack,
  input  logic [NB_DATA-1:0] i_dmem_rdata,
  output logic               o_stall,
  output logic [NB_DATA-1:0] o_read_data,
  output logic               o_bus_err,
  output logic               o_misaligned,
  output logic               o_pc_src,
  output logic [NB_DATA-1:0] o_branch_addr,
  output logic               o_halted
);

  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE,
    HALTED
  } state_t;

  state_t state, state_nx;

  logic               sz_word;
  logic               sz_half;
  logic               sz_byte;
  logic               any_op;
  logic               mis;
  logic               start;
  logic               to_hit;
  logic [CW-1:0]      cnt;
  logic [3:0]         be_c;
  logic [NB_DATA-1:0] wdata_c;
  logic [7:0]         lane_b;
  logic [15:0]        lane_h;
  logic [NB_DATA-1:0] load_ext;
  logic [NB_DATA-1:0] read_q;
  logic [1:0]         a_lo;

  assign a_lo   = MEM_alu_result[1:0];
  assign to_hit = (cnt == CW'(TIMEOUT - 1));

  // Size priority, misalignment and access start decode
  always_comb begin
    sz_word = MEM_word_en |
              !(MEM_byte_en | MEM_halfword_en);
    sz_half = !sz_word & MEM_halfword_en;
    sz_byte = !sz_word & !sz_half;
    any_op  = MEM_mem_read | MEM_mem_write;
    mis     = any_op &
              ((sz_half & a_lo[0]) |
               (sz_word & (a_lo != 2'b00)));
    start   = (state == IDLE) & any_op &
              !mis & !MEM_hlt;
  end

  // Byte enables and lane-replicated store data
  always_comb begin
    be_c    = 4'b1111;
    wdata_c = MEM_data_b;
    unique case (1'b1)
      sz_byte: begin
        be_c    = 4'b0001 << a_lo;
        wdata_c = {4{MEM_data_b[7:0]}};
      end
      sz_half: begin
        be_c    = a_lo[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{MEM_data_b[15:0]}};
      end
      default: begin
        be_c    = 4'b1111;
        wdata_c = MEM_data_b;
      end
    endcase
  end

  // Load lane select and sign/zero extension
  always_comb begin
    lane_b = i_dmem_rdata[7:0];
    unique case (a_lo)
      2'd0: lane_b = i_dmem_rdata[7:0];
      2'd1: lane_b = i_dmem_rdata[15:8];
      2'd2: lane_b = i_dmem_rdata[23:16];
      default: lane_b = i_dmem_rdata[31:24];
    endcase
    lane_h = a_lo[1] ? i_dmem_rdata[31:16]
                     : i_dmem_rdata[15:0];
    load_ext = i_dmem_rdata;
    unique case (1'b1)
      sz_byte: load_ext =
        {{24{!i_load_unsigned & lane_b[7]}}, lane_b};
      sz_half: load_ext =
        {{16{!i_load_unsigned & lane_h[15]}}, lane_h};
      default: load_ext = i_dmem_rdata;
    endcase
  end

  // State register
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) state <= IDLE;
    else            state <= state_nx;
  end

  // Next-state logic; halt beats a simultaneous access
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (MEM_hlt)    state_nx = HALTED;
        else if (start) state_nx = ACCESS;
      end
      ACCESS: begin
        if (i_dmem_ack | to_hit) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = HALTED;
    endcase
  end

  // Request, timeout counter and result registers
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_dmem_req   <= 1'b0;
      o_dmem_we    <= 1'b0;
      o_dmem_addr  <= '0;
      o_dmem_be    <= 4'b0000;
      o_dmem_wdata <= '0;
      read_q       <= '0;
      o_bus_err    <= 1'b0;
      cnt          <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            o_dmem_req   <= 1'b1;
            o_dmem_we    <= MEM_mem_write;
            o_dmem_addr  <= {MEM_alu_result[NB_DATA-1:2],
                             2'b00};
            o_dmem_be    <= be_c;
            o_dmem_wdata <= wdata_c;
            cnt          <= '0;
          end
        end
        ACCESS: begin
          if (i_dmem_ack) begin
            o_dmem_req <= 1'b0;
            read_q     <= MEM_mem_write ? '0 : load_ext;
            o_bus_err  <= 1'b0;
          end else if (to_hit) begin
            o_dmem_req <= 1'b0;
            read_q     <= '0;
            o_bus_err  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Combinational pipeline-facing outputs
  always_comb begin
    o_misaligned = mis;
    o_stall      = start | (state == ACCESS);
    o_halted     = (state == HALTED);
    o_pc_src     = MEM_branch & MEM_zero & !o_halted;
    o_read_data  = mis ? '0 : read_q;
  end

  assign o_branch_addr = MEM_branch_addr;

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit.
// Vector table plus scoreboard of load results.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rd, wr, b_en, h_en, w_en, uns;
  logic [31:0] addr, data_b, br_addr, rdata;
  logic        br, zero, hlt, ack;
  logic        req, we, stall, bus_err, mis, pc_src, halted;
  logic [31:0] d_addr, wdata, read_data, br_out;
  logic [3:0]  be;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  sz;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] data_b;
    logic [31:0] rdata;
    int          delay;
    logic        e_mis;
    logic        e_we;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic [31:0] e_rd;
  } vec_t;

  typedef struct {
    logic [31:0] rd;
    logic        err;
  } exp_t;

  vec_t vecs[13];
  exp_t sb[$];

  mem_access_unit #(.NB_DATA(32), .TIMEOUT(16)) dut (
    .i_clock         (clk),
    .i_reset_n       (rst_n),
    .MEM_mem_read    (rd),
    .MEM_mem_write   (wr),
    .MEM_byte_en     (b_en),
    .MEM_halfword_en (h_en),
    .MEM_word_en     (w_en),
    .i_load_unsigned (uns),
    .MEM_alu_result  (addr),
    .MEM_data_b      (data_b),
    .MEM_branch      (br),
    .MEM_zero        (zero),
    .MEM_branch_addr (br_addr),
    .MEM_hlt         (hlt),
    .o_dmem_req      (req),
    .o_dmem_we       (we),
    .o_dmem_addr     (d_addr),
    .o_dmem_be       (be),
    .o_dmem_wdata    (wdata),
    .i_dmem_ack      (ack),
    .i_dmem_rdata    (rdata),
    .o_stall         (stall),
    .o_read_data     (read_data),
    .o_bus_err       (bus_err),
    .o_misaligned    (mis),
    .o_pc_src        (pc_src),
    .o_branch_addr   (br_out),
    .o_halted        (halted)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  task automatic clr;
    rd = 0; wr = 0; b_en = 0; h_en = 0; w_en = 0;
    uns = 0; addr = 0; data_b = 0; hlt = 0;
    ack = 0; rdata = 0;
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    rd = v.rd; wr = v.wr; uns = v.uns;
    {w_en, h_en, b_en} = v.sz;
    addr = v.addr; data_b = v.data_b;
  endtask

  task automatic run_vec(input vec_t v, input int k);
    int   stalls;
    int   waits;
    bit   done;
    bit   seen;
    exp_t e;
    drive(v);
    #1;
    chk($sformatf("v%0d mis", k), 32'(mis), 32'(v.e_mis));
    if (v.e_mis) begin
      chk($sformatf("v%0d mis stall", k), 32'(stall), 0);
      chk($sformatf("v%0d mis rdata", k), read_data, 0);
      cyc();
      chk($sformatf("v%0d mis req", k), 32'(req), 0);
      clr();
      cyc();
      return;
    end
    sb.push_back('{v.e_rd, 1'b0});
    stalls = 0; waits = 0; done = 0; seen = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      if (stall) stalls++;
      if (req) begin
        if (!seen) begin
          seen = 1;
          chk($sformatf("v%0d we", k), 32'(we), 32'(v.e_we));
          chk($sformatf("v%0d be", k), 32'(be), 32'(v.e_be));
          chk($sformatf("v%0d wdata", k), wdata, v.e_wdata);
          chk($sformatf("v%0d addr", k), d_addr,
              v.addr & 32'hFFFF_FFFC);
        end
        if (waits == v.delay) begin
          ack = 1;
          rdata = v.rdata;
        end
        waits++;
      end
      cyc();
      ack = 0;
      rdata = 32'h5A5A_5A5A;
      if (!stall && !req && stalls > 0) done = 1;
    end
    if (!done) begin
      chk($sformatf("v%0d done timeout", k), 0, 1);
    end else begin
      e = sb.pop_front();
      chk($sformatf("v%0d read_data", k), read_data, e.rd);
      chk($sformatf("v%0d bus_err", k), 32'(bus_err),
          32'(e.err));
      chk($sformatf("v%0d stalls", k), stalls,
          2 + v.delay);
    end
    clr();
    cyc();
  endtask

  initial begin
    int   reqc;
    exp_t e;
    vec_t lv;
    //       rd wr  sz     uns addr        data_b
    //       rdata        dly mis we be      wdata        rd
    vecs[0]  = '{1, 0, 3'b001, 0, 32'h7, 32'h0,
                 32'h80FF_1234, 0, 0, 0, 4'b1000,
                 32'h0, 32'hFFFF_FF80};
    vecs[1]  = '{1, 0, 3'b100, 0, 32'h6, 32'h0,
                 32'h0, 0, 1, 0, 4'b0000,
                 32'h0, 32'h0};
    vecs[2]  = '{0, 1, 3'b010, 0, 32'h2, 32'h0000_ABCD,
                 32'hDEAD_BEEF, 0, 0, 1, 4'b1100,
                 32'hABCD_ABCD, 32'h0};
    vecs[3]  = '{1, 0, 3'b001, 1, 32'h6, 32'h0,
                 32'h80FF_1234, 2, 0, 0, 4'b0100,
                 32'h0, 32'h0000_00FF};
    vecs[4]  = '{1, 0, 3'b010, 0, 32'h2, 32'h0,
                 32'h80FF_1234, 1, 0, 0, 4'b1100,
                 32'h0, 32'hFFFF_80FF};
    vecs[5]  = '{1, 0, 3'b010, 1, 32'h0, 32'h0,
                 32'h80FF_9234, 0, 0, 0, 4'b0011,
                 32'h0, 32'h0000_9234};
    vecs[6]  = '{1, 0, 3'b100, 1, 32'h8, 32'h1111_2222,
                 32'h80FF_1234, 3, 0, 0, 4'b1111,
                 32'h1111_2222, 32'h80FF_1234};
    vecs[7]  = '{0, 1, 3'b001, 0, 32'h1, 32'h1234_56A5,
                 32'h0, 0, 0, 1, 4'b0010,
                 32'hA5A5_A5A5, 32'h0};
    vecs[8]  = '{1, 0, 3'b000, 0, 32'hC, 32'h0,
                 32'h0BAD_F00D, 0, 0, 0, 4'b1111,
                 32'h0, 32'h0BAD_F00D};
    vecs[9]  = '{1, 1, 3'b010, 0, 32'h0, 32'h0000_1357,
                 32'hFFFF_FFFF, 0, 0, 1, 4'b0011,
                 32'h1357_1357, 32'h0};
    vecs[10] = '{0, 1, 3'b010, 0, 32'h3, 32'h0,
                 32'h0, 0, 1, 0, 4'b0000,
                 32'h0, 32'h0};
    vecs[11] = '{1, 0, 3'b101, 0, 32'h4, 32'h0,
                 32'hCAFE_BABE, 0, 0, 0, 4'b1111,
                 32'h0, 32'hCAFE_BABE};
    vecs[12] = '{1, 0, 3'b001, 0, 32'h3, 32'h0,
                 32'h7F00_0000, 0, 0, 0, 4'b1000,
                 32'h0, 32'h0000_007F};

    clr();
    br = 0; zero = 0; br_addr = 32'h0000_0400;
    #2;
    chk("rst req", 32'(req), 0);
    chk("rst be", 32'(be), 0);
    chk("rst read_data", read_data, 0);
    chk("rst halted", 32'(halted), 0);
    chk("rst stall", 32'(stall), 0);
    cyc();
    rst_n = 1;
    cyc();

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Timeout: no ack for TIMEOUT cycles
    sb.push_back('{32'h0, 1'b1});
    w_en = 1; rd = 1; addr = 32'h10;
    reqc = 0;
    for (int c = 0; c < 40; c++) begin
      cyc();
      if (req) reqc++;
      else break;
    end
    e = sb.pop_front();
    chk("to req cycles", reqc, 16);
    chk("to bus_err", 32'(bus_err), 32'(e.err));
    chk("to read_data", read_data, e.rd);
    chk("to stall in done", 32'(stall), 0);
    clr();
    cyc();
    chk("to idle req", 32'(req), 0);

    // Ack arriving on the last counted cycle wins
    lv = vecs[8];
    lv.delay = 15;
    run_vec(lv, 20);

    // Ack in IDLE is ignored
    ack = 1; rdata = 32'h1234_5678;
    cyc();
    chk("idle ack read_data", read_data, 32'h0BAD_F00D);
    chk("idle ack req", 32'(req), 0);
    chk("idle ack stall", 32'(stall), 0);
    clr();
    cyc();

    // Branch resolve
    br = 1; zero = 1; br_addr = 32'h0000_0ABC;
    #1;
    chk("pc_src taken", 32'(pc_src), 1);
    chk("branch addr", br_out, 32'h0000_0ABC);
    zero = 0;
    #1;
    chk("pc_src not taken", 32'(pc_src), 0);
    br = 0;

    // Reset abandons an in-flight access
    cyc();
    w_en = 1; rd = 1; addr = 32'h20; data_b = 32'h99;
    cyc();
    chk("mid req", 32'(req), 1);
    rst_n = 0;
    clr();
    #1;
    chk("mid rst req", 32'(req), 0);
    chk("mid rst we", 32'(we), 0);
    chk("mid rst addr", d_addr, 0);
    chk("mid rst be", 32'(be), 0);
    chk("mid rst wdata", wdata, 0);
    chk("mid rst read_data", read_data, 0);
    chk("mid rst stall", 32'(stall), 0);
    cyc();
    rst_n = 1;
    cyc();
    run_vec(vecs[0], 30);

    // Halt beats a simultaneous load and is sticky
    hlt = 1; rd = 1; w_en = 1; addr = 32'h40;
    #1;
    chk("hlt stall", 32'(stall), 0);
    cyc();
    chk("hlt halted", 32'(halted), 1);
    chk("hlt req", 32'(req), 0);
    hlt = 0; br = 1; zero = 1;
    reqc = 0;
    for (int c = 0; c < 5; c++) begin
      cyc();
      if (req || stall || !halted) reqc++;
    end
    chk("hlt sticky", reqc, 0);
    chk("hlt pc_src", 32'(pc_src), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

MEM-stage data-memory access controller for the 5-stage pipelined MIPS core. It consumes the EX/MEM pipeline register outputs and drives a data-memory port with a req/ack handshake. It performs byte, halfword and word lane steering, and sign/zero extension on loads. It stalls the pipeline while an access is outstanding, resolves the branch decision, and latches the halt condition.

## Interface
- NB_DATA, 32, data and address width
- TIMEOUT, 16, maximum cycles in ACCESS waiting for ack before a bus error (≥2)

Ports:
- i_clock  in  1  clock; all state updates on the rising edge
- i_reset_n  in  1  reset, asynchronous, active-low
- MEM_mem_read  in  1  load request
- MEM_mem_write  in  1  store request
- MEM_byte_en / MEM_halfword_en / MEM_word_en  in  1 each  access size
- i_load_unsigned  in  1  1 = zero-extend loads, 0 = sign-extend
- MEM_alu_result  in  NB_DATA  byte address
- MEM_data_b  in  NB_DATA  store data (low bits significant)
- MEM_branch, MEM_zero  in  1  branch control and ALU zero flag
- MEM_branch_addr  in  NB_DATA  branch target
- MEM_hlt  in  1  halt instruction in MEM
- o_dmem_req  out  1  memory request, registered
- o_dmem_we  out  1  1 = write
- o_dmem_addr  out  NB_DATA  word-aligned address, {addr[31:2],2'b00}
- o_dmem_be  out  4  byte lane enables
- o_dmem_wdata  out  NB_DATA  lane-replicated store data
- i_dmem_ack  in  1  access complete; rdata valid in the same cycle
- i_dmem_rdata  in  NB_DATA  read word
- o_stall  out  1  hold PC, IF/ID, ID/EX and EX/MEM
- o_read_data  out  NB_DATA  extended load result
- o_bus_err  out  1  timeout flag, valid in DONE
- o_misaligned  out  1  misaligned access, combinational
- o_pc_src  out  1  take branch
- o_branch_addr  out  NB_DATA  MEM_branch_addr passthrough
- o_halted  out  1  core halted, sticky

## Operation
- FSM states: IDLE, ACCESS, DONE, HALTED. Reset state is IDLE.
- Size priority is word > halfword > byte. If no size bit is set, the access is treated as a word.
- If read and write are both set, the write wins.
- Misalignment:
  - A halfword access with addr[0]=1 is misaligned.
  - A word access with addr[1:0]≠0 is misaligned.
  - A misaligned access raises o_misaligned, issues no request, does not stall, and leaves o_read_data at 0 for that cycle.
- start = IDLE & (read|write) & !misaligned & !MEM_hlt.
- IDLE transitions:
  - start → ACCESS. Register o_dmem_req=1, we, addr, be and wdata; clear the timeout counter.
  - MEM_hlt → HALTED. Halt beats a simultaneous access.
- ACCESS transitions:
  - Hold all dmem outputs stable until ack.
  - On i_dmem_ack: → DONE, drop req, capture the extracted read word (0 for stores), o_bus_err=0.
  - On counter == TIMEOUT-1 without ack: → DONE, drop req, o_read_data=0, o_bus_err=1.
  - Otherwise increment the counter.
- DONE → IDLE unconditionally. o_read_data and o_bus_err hold until the next DONE.
- HALTED is terminal until reset. No requests are issued, o_stall=0, o_pc_src=0.
- Byte enables:
  - byte → 4'b0001<<addr[1:0]
  - halfword → addr[1] ? 4'b1100 : 4'b0011
  - word → 4'b1111
- Store data:
  - byte → {4{data_b[7:0]}}
  - halfword → {2{data_b[15:0]}}
  - word → data_b
- Load extraction: select the lane by addr, then extend to 32 bits per i_load_unsigned. Word loads ignore i_load_unsigned.
- o_stall = start | (state==ACCESS). It is combinational and low in DONE, so the pipeline advances at the end of DONE.
- o_pc_src = MEM_branch & MEM_zero & !o_halted.
- Upstream must hold all MEM_* inputs stable while o_stall=1.

## Timing
- Reset (async assert) forces these values immediately: state=IDLE, o_dmem_req=0, o_dmem_we=0, o_dmem_addr=0, o_dmem_be=0, o_dmem_wdata=0, o_read_data=0, o_bus_err=0, o_halted=0, counter=0.
- An access in flight is abandoned on reset. Memory must tolerate a req drop without ack.
- Minimum access latency:
  - Cycle 0: start, o_stall=1.
  - Cycle 1: req=1, ack=1.
  - Cycle 2: DONE, o_read_data valid.
  - Result: 2 stall cycles and 3 cycles total.
- Each extra wait cycle without ack adds one stall cycle.
- Timeout: the bus error appears in DONE TIMEOUT+1 cycles after start.
- An ack arriving in the same cycle as counter==TIMEOUT-1 wins: o_bus_err=0.
- An ack while in IDLE or DONE is ignored.
- o_halted rises one cycle after MEM_hlt is sampled in IDLE.
- A halt arriving during ACCESS waits for DONE→IDLE.

## Test plan
- Byte load, addr 0x0000_0007, rdata 0x80FF_1234, signed, ack one cycle after req → be=4'b1000, o_read_data=0xFFFF_FF80 in DONE, o_stall high exactly 2 cycles.
- Halfword store, addr 0x0000_0002, data_b 0x0000_ABCD → we=1, be=4'b1100, wdata=0xABCD_ABCD, o_read_data=0 in DONE.
- Word load at addr 0x0000_0006 → o_misaligned=1, o_dmem_req never asserts, o_stall=0.
- No ack with TIMEOUT=16 → req high 16 cycles, then DONE with o_bus_err=1, o_read_data=0, then IDLE.
- MEM_hlt with MEM_mem_read set in IDLE → no req, o_halted=1 next cycle and sticky; MEM_branch=MEM_zero=1 afterwards → o_pc_src=0.
- Drive i_reset_n low mid-ACCESS (req=1), then release → req and all outputs 0 immediately; the next load completes normally.
